// File: rtl/tport_pkg.sv
// Shared types and defaults for the CPU test-port capture block.
package tport_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic [29:0] DEF_TEST_PORT = 30'hFF;
   localparam logic [31:0] DEF_BEGIN_SYM = 32'h00000168;
   localparam logic [31:0] DEF_END_SYM   = 32'hFFFFFD5D;

   // CPU stores are little-endian; markers and stored words use readable order.
   function automatic logic [31:0] bswap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/tport_fifo.sv
// First-word fall-through FIFO with sticky overflow; storage is not reset.
module tport_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   // Extra pointer MSB tells a full ring from an empty one.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/tport_capture.sv
// Snoops CPU stores to the test port and captures the words between the
// begin and end markers into a FIFO for a downstream checker.
module tport_capture
   import tport_pkg::*;
#(
   parameter logic [29:0] TEST_PORT = DEF_TEST_PORT,
   parameter logic [31:0] BEGIN_SYM = DEF_BEGIN_SYM,
   parameter logic [31:0] END_SYM   = DEF_END_SYM,
   parameter int          DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] addr,
   input  logic [31:0] data,
   input  logic        wen,
   input  logic        pop,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [6:0]  word_cnt,
   output logic        armed,
   output logic        done,
   output logic        overflow
);

   state_t      state;
   state_t      state_nxt;
   logic        wen_q;
   logic        event_q;
   logic        push;
   logic [31:0] swapped;

   assign swapped = bswap(data);

   // A D-cache stall holds wen high; only its rising edge counts.
   assign event_q = (addr == TEST_PORT) && wen && !wen_q;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (event_q && swapped == BEGIN_SYM) state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (event_q) begin
               push = 1'b1;
               if (swapped == END_SYM) state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         wen_q    <= 1'b0;
         word_cnt <= '0;
      end else begin
         state <= state_nxt;
         wen_q <= wen;
         if (push && word_cnt != 7'd127) word_cnt <= word_cnt + 7'd1;
      end
   end

   assign armed = (state == ST_CAPTURE);
   assign done  = (state == ST_DONE);

   tport_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (swapped),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .overflow  (overflow)
   );

endmodule

// File: tb/tb_tport_capture.sv
// Scoreboard bench: stimulus queues expected words, a monitor drains and compares.
module tb_tport_capture;

   logic        clk;
   logic        rst;
   logic [29:0] addr;
   logic [31:0] data;
   logic        wen;
   logic        pop;
   logic        out_valid;
   logic [31:0] out_data;
   logic [6:0]  word_cnt;
   logic        armed;
   logic        done;
   logic        overflow;

   int checks;
   int failures;
   logic [31:0] exp_q[$];
   logic drain_en;

   tport_capture #(
      .TEST_PORT (30'hFF),
      .BEGIN_SYM (32'h00000168),
      .END_SYM   (32'hFFFFFD5D),
      .DEPTH     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data      (data),
      .wen       (wen),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (out_data),
      .word_cnt  (word_cnt),
      .armed     (armed),
      .done      (done),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: 1ns after each falling edge, consume the head if draining.
   initial begin
      pop = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (drain_en && rst && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_entry: got %h expected none", out_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  failures++;
                  $display("FAIL out_data: got %h expected %h", out_data, e);
               end
            end
            pop = 1'b1;
         end else begin
            pop = 1'b0;
         end
      end
   end

   // One CPU store; wen held high for ncyc cycles, then low for one.
   task automatic wr(input logic [29:0] a, input logic [31:0] d, input int ncyc);
      @(negedge clk);
      addr = a; data = d; wen = 1'b1;
      repeat (ncyc - 1) @(negedge clk);
      @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk); #2;
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_out_valid"}, out_valid, 0);
   endtask

   task automatic sample;
      @(negedge clk); #2;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; addr = '0; data = '0; wen = 1'b0; drain_en = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_armed", armed, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b1;
      drain_en = 1'b1;

      // Data before the begin marker is ignored.
      wr(30'hFF, 32'h05000000, 1);
      sample();
      chk("idle_ignore_valid", out_valid, 0);
      chk("idle_ignore_armed", armed, 0);

      wr(30'hFF, 32'h68010000, 1);
      sample();
      chk("begin_armed", armed, 1);
      chk("begin_not_pushed", out_valid, 0);
      chk("begin_word_cnt", word_cnt, 0);

      exp_q.push_back(32'd0); wr(30'hFF, 32'h00000000, 1);
      exp_q.push_back(32'd1); wr(30'hFF, 32'h01000000, 1);
      wait_drain("two_words");
      chk("two_word_cnt", word_cnt, 2);
      chk("two_armed", armed, 1);

      // Stalled store: three cycles of wen, one event.
      exp_q.push_back(32'd1); wr(30'hFF, 32'h01000000, 3);
      wait_drain("stall");
      chk("stall_word_cnt", word_cnt, 3);

      // Other address in CAPTURE.
      wr(30'h100, 32'h07000000, 1);
      wait_drain("other_addr");
      chk("other_addr_word_cnt", word_cnt, 3);

      // Fill without draining: 9 writes into 8 entries.
      drain_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         logic [31:0] w;
         w = 32'h10 + i;
         if (i < 8) exp_q.push_back(w);
         wr(30'hFF, {w[7:0], w[15:8], w[23:16], w[31:24]}, 1);
      end
      sample();
      chk("full_overflow", overflow, 1);
      chk("full_word_cnt", word_cnt, 12);
      chk("full_valid", out_valid, 1);

      // Push and pop together while full: nothing further lost.
      @(negedge clk);
      drain_en = 1'b1;
      addr = 30'hFF; data = 32'h19000000; wen = 1'b1;
      exp_q.push_back(32'h19);
      @(negedge clk);
      wen = 1'b0;
      wait_drain("full_pushpop");
      chk("full_pushpop_word_cnt", word_cnt, 13);

      // End marker is stored, then everything is ignored.
      exp_q.push_back(32'hFFFFFD5D); wr(30'hFF, 32'h5DFDFFFF, 1);
      wait_drain("end");
      chk("end_done", done, 1);
      chk("end_armed", armed, 0);
      chk("end_word_cnt", word_cnt, 14);
      wr(30'hFF, 32'h01000000, 1);
      wait_drain("after_done");
      chk("after_done_word_cnt", word_cnt, 14);

      // Reset mid-capture discards the FIFO and needs a fresh begin marker.
      rst = 1'b0; sample(); rst = 1'b1;
      wr(30'hFF, 32'h68010000, 1);
      drain_en = 1'b0;
      for (int i = 0; i < 5; i++) wr(30'hFF, 32'h03000000, 1);
      sample();
      chk("mid_word_cnt", word_cnt, 5);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_word_cnt", word_cnt, 0);
      chk("mid_rst_armed", armed, 0);
      chk("mid_rst_overflow", overflow, 0);
      @(negedge clk);
      rst = 1'b1;
      drain_en = 1'b1;
      wr(30'hFF, 32'h02000000, 1);
      wait_drain("post_rst");
      chk("post_rst_word_cnt", word_cnt, 0);
      chk("post_rst_armed", armed, 0);

      // Saturation of word_cnt.
      wr(30'hFF, 32'h68010000, 1);
      for (int i = 0; i < 130; i++) begin
         exp_q.push_back(32'(i));
         wr(30'hFF, {8'(i), 8'h00, 8'h00, 8'h00}, 1);
      end
      wait_drain("sat");
      chk("sat_word_cnt", word_cnt, 127);
      chk("sat_overflow", overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
